seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial pattern detector: the generalised successor to our fixed 4-bit Mealy sequence detectors. It scans a one-bit input stream for an N-bit compile-time pattern. It raises a registered one-cycle match pulse and selects overlapping or non-overlapping detection at run time. It also gates input with a sample enable and keeps a saturating match counter, and it sits between a serial front end and the status/interrupt logic.

## Interface
- `N`, 4: pattern length in bits; legal range 2..16, elaboration error otherwise.
- `PATTERN`, 4'b1101: N-bit pattern; bit N-1 is the first bit received.
- `CNT_W`, 8: match counter width; legal range 1..32.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `x`  in  1  serial data bit, sampled on rising edge when `en`=1.
- `en`  in  1  sample enable; bits with `en`=0 are ignored.
- `overlap`  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- `clr_cnt`  in  1  synchronous clear of `match_cnt`.
- `z`  out  1  registered match pulse.
- `match_cnt`  out  CNT_W  saturating count of matches.
- `progress`  out  $clog2(N)  current match progress p (0..N-1), registered.

## Operation
- State is progress p. It is the length of the longest suffix of accepted bits that is a proper prefix of PATTERN. "Accepted bits" means bits since reset, or since the last match in non-overlap mode. This is the generalised form of a hand-coded s0..s3 chain, including its self-loops (for 1101, "111" holds p=2).
- On an edge with `en`=1, form candidate c = (first p pattern bits) followed by x.
  - If c equals PATTERN (p=N-1 and x matches the last bit), this is a match.
  - Otherwise p becomes the longest suffix of c that is a proper prefix of PATTERN.
- After a match:
  - `overlap`=1: p becomes B, the longest proper border of PATTERN (longest proper prefix that is also a suffix). B is a constant computed at elaboration; for 1101, B=1; for 1010, B=2.
  - `overlap`=0: p becomes 0.
  - `overlap` matters only on the match edge; changing it at other times has no effect on p.
- On an edge with `en`=0: p holds, `z` is 0, and the counter holds.
- The transition/failure function is constant logic derived from PATTERN at elaboration. No runtime pattern loading.
- `match_cnt`:
  - Increments by 1 on each match and saturates at 2^CNT_W−1 (no wrap).
  - If `clr_cnt`=1 alone, it becomes 0.
  - If `clr_cnt`=1 on a match edge, it becomes 1 (clear, then count).

## Timing
- While `rst_n`=0, asynchronously: p=0, `z`=0, `match_cnt`=0, `progress`=0. Deassertion is synchronised externally. The first sample is taken on the first rising edge with `rst_n`=1.
- Reset mid-pattern discards all partial progress; no match can span a reset.
- `z` goes high for exactly one cycle, starting on the edge that samples the final pattern bit (Mealy decision, registered output). Latency: 1 clock from the final bit to `z`.
- Back-to-back `z` pulses are possible only when `overlap`=1 and B=N-1 (for example, an all-ones pattern).
- `progress` and `match_cnt` update on the same edge as `z`.
- No combinational path from any input to any output.

## Test plan
- PATTERN=1101, `overlap`=1, `en`=1, stream 1,1,0,1,1,0,1 -> `z` pulses after bit 4 and bit 7; `match_cnt`=2; `progress` after bit 4 is 1.
- Same stream, `overlap`=0 -> `z` pulses after bit 4 only; `match_cnt`=1; `progress` after bit 7 is 1.
- PATTERN=1101, stream 1,1,1,1,0,1 -> `progress` reads 1,2,2,2,3, then `z` pulses after bit 6; PATTERN=1010 with `overlap`=1 and stream 1,0,1,0,1,0 -> `z` after bits 4 and 6.
- Bits 1,1 then one cycle with `en`=0 and `x`=0, then 0,1 with `en`=1 -> exactly one `z` pulse after the final 1; `progress` holds 2 through the gap.
- Bits 1,1,0, then `rst_n` pulsed low, then bit 1 -> no `z`; all outputs read 0 during reset; `progress`=1 afterward.
- CNT_W=2, five matches -> `match_cnt` reaches 3 and holds. Then `clr_cnt`=1 on a match edge -> `match_cnt`=1. Then `clr_cnt`=1 with no match -> 0.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: serial detector for an N-bit constant pattern with overlap select, sample enable and saturating match count.
module seq_detect_param #(
  parameter int N = 4,
  parameter logic [N-1:0] PATTERN = 4'b1101,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  input  logic en,
  input  logic overlap,
  input  logic clr_cnt,
  output logic z,
  output logic [CNT_W-1:0] match_cnt,
  output logic [$clog2(N)-1:0] progress
);
  localparam int PW = $clog2(N);
  if (N < 2 || N > 16) begin : g_bad_n
    $error("seq_detect_param: N must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("seq_detect_param: CNT_W must be in 1..32");
  end
  // Longest suffix of (first p pattern bits, then b) that is a proper prefix of PATTERN.
  function automatic int next_p(input int p, input logic b);
    int c;
    c = ((int'(PATTERN) >> (N - p)) << 1) | int'(b);
    for (int k = N - 1; k >= 1; k--)
      if (k <= p + 1 && (c & ((1 << k) - 1)) == (int'(PATTERN) >> (N - k))) return k;
    return 0;
  endfunction
  function automatic int border();
    for (int k = N - 1; k >= 1; k--)
      if ((int'(PATTERN) & ((1 << k) - 1)) == (int'(PATTERN) >> (N - k))) return k;
    return 0;
  endfunction
  localparam int B = border();
  logic [PW-1:0] tab0 [N];
  logic [PW-1:0] tab1 [N];
  for (genvar i = 0; i < N; i++) begin : g_tab
    assign tab0[i] = PW'(next_p(i, 1'b0));
    assign tab1[i] = PW'(next_p(i, 1'b1));
  end
  logic match;
  logic [PW-1:0] p_next;
  always_comb begin
    match  = en && progress == PW'(N - 1) && x == PATTERN[0];
    p_next = match ? (overlap ? PW'(B) : '0) : en ? (x ? tab1[progress] : tab0[progress]) : progress;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      progress  <= '0;
      z         <= 1'b0;
      match_cnt <= '0;
    end else begin
      progress  <= p_next;
      z         <= match;
      match_cnt <= clr_cnt ? CNT_W'(match) : (match && !(&match_cnt)) ? match_cnt + CNT_W'(1) : match_cnt;
    end
  end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed checks on a 1101 detector (CNT_W=8) and a 1010 detector (CNT_W=2) sharing one input stream.
module tb_seq_detect_param;
  logic clk = 0, rst_n = 0, x = 0, en = 0, overlap = 0, clr_cnt = 0;
  logic za, zb;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b, prog_a, prog_b;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.N(4), .PATTERN(4'b1101), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .overlap(overlap), .clr_cnt(clr_cnt),
    .z(za), .match_cnt(cnt_a), .progress(prog_a));
  seq_detect_param #(.N(4), .PATTERN(4'b1010), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .overlap(overlap), .clr_cnt(clr_cnt),
    .z(zb), .match_cnt(cnt_b), .progress(prog_b));

  task automatic drive(input logic b, input logic e);
    x = b; en = e;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst_n = 0; x = 0; en = 0; clr_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    @(posedge clk); #1;
    checks++; if (za !== 1'b0 || zb !== 1'b0) begin failures++; $display("FAIL reset_z got=%b%b exp=00", za, zb); end
    checks++; if (cnt_a !== 8'd0 || cnt_b !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d,%0d exp=0,0", cnt_a, cnt_b); end
    checks++; if (prog_a !== 2'd0 || prog_b !== 2'd0) begin failures++; $display("FAIL reset_progress got=%0d,%0d exp=0,0", prog_a, prog_b); end
    rst_n = 1;
  endtask

  task automatic test_overlap;
    logic [6:0] bits = 7'b1101101, zexp = 7'b0001001;
    int pexp[7] = '{1, 2, 3, 1, 2, 3, 1};
    do_reset(); overlap = 1;
    for (int i = 0; i < 7; i++) begin
      drive(bits[6-i], 1);
      checks++; if (za !== zexp[6-i]) begin failures++; $display("FAIL overlap_z bit%0d got=%b exp=%b", i+1, za, zexp[6-i]); end
      checks++; if (prog_a !== 2'(pexp[i])) begin failures++; $display("FAIL overlap_progress bit%0d got=%0d exp=%0d", i+1, prog_a, pexp[i]); end
    end
    checks++; if (cnt_a !== 8'd2) begin failures++; $display("FAIL overlap_cnt got=%0d exp=2", cnt_a); end
  endtask

  task automatic test_nonoverlap;
    logic [6:0] bits = 7'b1101101, zexp = 7'b0001000;
    int pexp[7] = '{1, 2, 3, 0, 1, 0, 1};
    do_reset(); overlap = 0;
    for (int i = 0; i < 7; i++) begin
      drive(bits[6-i], 1);
      checks++; if (za !== zexp[6-i]) begin failures++; $display("FAIL nonoverlap_z bit%0d got=%b exp=%b", i+1, za, zexp[6-i]); end
      checks++; if (prog_a !== 2'(pexp[i])) begin failures++; $display("FAIL nonoverlap_progress bit%0d got=%0d exp=%0d", i+1, prog_a, pexp[i]); end
    end
    checks++; if (cnt_a !== 8'd1) begin failures++; $display("FAIL nonoverlap_cnt got=%0d exp=1", cnt_a); end
  endtask

  task automatic test_self_loop;
    logic [5:0] bits = 6'b111101, zexp = 6'b000001;
    int pexp[6] = '{1, 2, 2, 2, 3, 1};
    do_reset(); overlap = 1;
    for (int i = 0; i < 6; i++) begin
      drive(bits[5-i], 1);
      checks++; if (za !== zexp[5-i]) begin failures++; $display("FAIL selfloop_z bit%0d got=%b exp=%b", i+1, za, zexp[5-i]); end
      checks++; if (prog_a !== 2'(pexp[i])) begin failures++; $display("FAIL selfloop_progress bit%0d got=%0d exp=%0d", i+1, prog_a, pexp[i]); end
    end
  endtask

  task automatic test_pattern_1010;
    logic [5:0] bits = 6'b101010, zexp = 6'b000101;
    int pexp[6] = '{1, 2, 3, 2, 3, 2};
    do_reset(); overlap = 1;
    for (int i = 0; i < 6; i++) begin
      drive(bits[5-i], 1);
      checks++; if (zb !== zexp[5-i]) begin failures++; $display("FAIL p1010_z bit%0d got=%b exp=%b", i+1, zb, zexp[5-i]); end
      checks++; if (prog_b !== 2'(pexp[i])) begin failures++; $display("FAIL p1010_progress bit%0d got=%0d exp=%0d", i+1, prog_b, pexp[i]); end
    end
    checks++; if (cnt_b !== 2'd2) begin failures++; $display("FAIL p1010_cnt got=%0d exp=2", cnt_b); end
  endtask

  task automatic test_enable_gap;
    do_reset(); overlap = 1;
    drive(1, 1); drive(1, 1);
    drive(0, 0);
    checks++; if (prog_a !== 2'd2 || za !== 1'b0) begin failures++; $display("FAIL gap_hold got=p%0d z%b exp=p2 z0", prog_a, za); end
    drive(0, 1);
    checks++; if (prog_a !== 2'd3 || za !== 1'b0) begin failures++; $display("FAIL gap_resume got=p%0d z%b exp=p3 z0", prog_a, za); end
    drive(1, 1);
    checks++; if (za !== 1'b1 || cnt_a !== 8'd1) begin failures++; $display("FAIL gap_match got=z%b cnt%0d exp=z1 cnt1", za, cnt_a); end
    drive(0, 0);
    checks++; if (za !== 1'b0 || prog_a !== 2'd1) begin failures++; $display("FAIL gap_pulse_end got=z%b p%0d exp=z0 p1", za, prog_a); end
  endtask

  task automatic test_reset_mid;
    overlap = 1;
    drive(1, 1); drive(1, 1); drive(0, 1);
    checks++; if (prog_a !== 2'd3) begin failures++; $display("FAIL midreset_pre got=%0d exp=3", prog_a); end
    #2 rst_n = 0;
    #1;
    checks++; if (za !== 1'b0 || cnt_a !== 8'd0 || prog_a !== 2'd0) begin failures++; $display("FAIL midreset_async got=z%b cnt%0d p%0d exp=z0 cnt0 p0", za, cnt_a, prog_a); end
    @(posedge clk); #1;
    rst_n = 1;
    drive(1, 1);
    checks++; if (za !== 1'b0 || prog_a !== 2'd1) begin failures++; $display("FAIL midreset_after got=z%b p%0d exp=z0 p1", za, prog_a); end
  endtask

  task automatic test_saturate_clear;
    int cexp[5] = '{1, 2, 3, 3, 3};
    do_reset(); overlap = 1;
    drive(1, 1); drive(0, 1);
    for (int m = 0; m < 5; m++) begin
      drive(1, 1); drive(0, 1);
      checks++; if (zb !== 1'b1 || cnt_b !== 2'(cexp[m])) begin failures++; $display("FAIL sat_match%0d got=z%b cnt%0d exp=z1 cnt%0d", m+1, zb, cnt_b, cexp[m]); end
    end
    drive(1, 1);
    clr_cnt = 1; drive(0, 1);
    checks++; if (zb !== 1'b1 || cnt_b !== 2'd1) begin failures++; $display("FAIL clr_on_match got=z%b cnt%0d exp=z1 cnt1", zb, cnt_b); end
    drive(1, 1);
    checks++; if (zb !== 1'b0 || cnt_b !== 2'd0) begin failures++; $display("FAIL clr_alone got=z%b cnt%0d exp=z0 cnt0", zb, cnt_b); end
    clr_cnt = 0;
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_self_loop();
    test_pattern_1010();
    test_enable_gap();
    test_reset_mid();
    test_saturate_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
